// File: rtl/fancy_counter.sv
// fancy_counter
// 16-bit enabled up-counter with a one-step history register and a
// combinational "fancy" output built from the current and previous count.
//
// Ports:
//   clk        in   1   rising-edge clock
//   nreset     in   1   synchronous active-low reset, priority over en
//   en         in   1   count enable
//   data       out  16  current count (register output)
//   fancy_data out  16  combinational function of count and history
//
// Optional build macro:
//   FANCY_COUNTER_ASSERT_EN  enables simulation-only assertions
module fancy_counter (
    input  logic        clk,
    input  logic        nreset,
    input  logic        en,
    output logic [15:0] data,
    output logic [15:0] fancy_data
);

    localparam int unsigned W = 16;

    localparam logic [W-1:0] FANCY_AT_0  = W'(17);
    localparam logic [W-1:0] FANCY_AT_1  = W'(1287);
    localparam logic [W-1:0] FANCY_AT_17 = W'(2137);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_delayed;
    logic [W-1:0] w_fancy;

    // Counter and history; history captures the pre-increment count
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_cnt     <= '0;
            r_delayed <= '0;
        end else if (en) begin
            r_cnt     <= W'(r_cnt + W'(1));
            r_delayed <= r_cnt;
        end
    end

    // Constant overrides keyed on the count only, else XOR-add with carry dropped
    always_comb begin
        w_fancy = W'((r_delayed ^ r_cnt) + r_cnt);
        if (r_cnt == W'(0)) begin
            w_fancy = FANCY_AT_0;
        end else if (r_cnt == W'(1)) begin
            w_fancy = FANCY_AT_1;
        end else if (r_cnt == W'(17)) begin
            w_fancy = FANCY_AT_17;
        end
    end

    assign data       = r_cnt;
    assign fancy_data = w_fancy;

`ifdef FANCY_COUNTER_ASSERT_EN
    logic r_seen_reset;

    // Marks that reset has been applied so X checks do not fire at power-up
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_seen_reset <= 1'b1;
        end
    end

    a_step: assert property (@(posedge clk)
        (nreset && en) |=> (r_cnt == W'(r_delayed + W'(1))));

    a_reset: assert property (@(posedge clk)
        (!nreset) |=> (r_cnt == '0 && r_delayed == '0));

    a_no_x: assert property (@(posedge clk)
        (r_seen_reset === 1'b1) |-> !$isunknown(fancy_data));
`endif

endmodule

// File: tb/tb_fancy_counter.sv
// Bench for fancy_counter: reference model feeds an expected-value queue at
// each driven edge; DUT outputs are popped and compared shortly after the edge.
module tb_fancy_counter;

    logic        clk;
    logic        nreset;
    logic        en;
    logic [15:0] data;
    logic [15:0] fancy_data;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] fancy;
    } exp_t;

    exp_t exp_q[$];

    int n_total;
    int n_bad;

    logic [15:0] m_cnt;
    logic [15:0] m_del;

    fancy_counter dut (
        .clk        (clk),
        .nreset     (nreset),
        .en         (en),
        .data       (data),
        .fancy_data (fancy_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_fancy(input logic [15:0] c, input logic [15:0] d);
        if (c == 16'd0)       return 16'd17;
        else if (c == 16'd1)  return 16'd1287;
        else if (c == 16'd17) return 16'd2137;
        else                  return 16'((d ^ c) + c);
    endfunction

    // Drive one edge, push the model's post-edge outputs, then check them
    task automatic step(input logic en_v, input logic nrst_v, input string tag);
        exp_t e;
        exp_t g;
        en     = en_v;
        nreset = nrst_v;
        if (!nrst_v) begin
            m_cnt = '0;
            m_del = '0;
        end else if (en_v) begin
            m_del = m_cnt;
            m_cnt = 16'(m_cnt + 16'd1);
        end
        e.data  = m_cnt;
        e.fancy = model_fancy(m_cnt, m_del);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 16'd0, 16'd1);
        end else begin
            g = exp_q.pop_front();
            check_val({tag, "_data"},  data,       g.data);
            check_val({tag, "_fancy"}, fancy_data, g.fancy);
        end
    endtask

    initial begin
        logic [15:0] held_d;
        logic [15:0] held_f;
        n_total = 0;
        n_bad   = 0;
        m_cnt   = '0;
        m_del   = '0;
        en      = 1'b1;
        nreset  = 1'b0;

        // Reset with en high, then idle
        step(1'b1, 1'b0, "reset");
        check_val("reset_fancy_17", fancy_data, 16'd17);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "idle");
        check_val("idle_data_0", data, 16'd0);
        check_val("idle_fancy_17", fancy_data, 16'd17);

        // Early count values with known answers
        step(1'b1, 1'b1, "cnt1");
        check_val("cnt1_fancy", fancy_data, 16'd1287);
        step(1'b1, 1'b1, "cnt2");
        check_val("cnt2_fancy", fancy_data, 16'd5);
        step(1'b1, 1'b1, "cnt3");
        check_val("cnt3_fancy", fancy_data, 16'd4);
        while (m_cnt != 16'd17) step(1'b1, 1'b1, "run17");
        check_val("cnt17_data", data, 16'd17);
        check_val("cnt17_fancy", fancy_data, 16'd2137);
        step(1'b1, 1'b1, "cnt18");
        check_val("cnt18_fancy", fancy_data, 16'd21);

        // Full run to the top of the range, every cycle against the model
        while (m_cnt != 16'hFFFF) step(1'b1, 1'b1, "run");
        check_val("top_data", data, 16'hFFFF);
        check_val("top_fancy_wrap", fancy_data, 16'h0000);
        step(1'b1, 1'b1, "wrap");
        check_val("wrap_data", data, 16'd0);
        check_val("wrap_fancy", fancy_data, 16'd17);
        step(1'b1, 1'b1, "after_wrap");
        check_val("after_wrap_data", data, 16'd1);
        check_val("after_wrap_fancy", fancy_data, 16'd1287);

        // Hold mid-count
        while (m_cnt != 16'd100) step(1'b1, 1'b1, "run100");
        held_d = data;
        held_f = fancy_data;
        check_val("cnt100_fancy", fancy_data, 16'd107);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, "hold");
            check_val("hold_data", data, held_d);
            check_val("hold_fancy", fancy_data, held_f);
        end
        step(1'b1, 1'b1, "resume");
        check_val("resume_data", data, 16'd101);
        check_val("resume_fancy", fancy_data, 16'd102);

        // Reset mid-count with en held high
        while (m_cnt != 16'd1078) step(1'b1, 1'b1, "run1078");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, "midreset");
            check_val("midreset_data", data, 16'd0);
            check_val("midreset_fancy", fancy_data, 16'd17);
        end
        step(1'b1, 1'b1, "post_reset");
        check_val("post_reset_data", data, 16'd1);

        // Random enable/reset mix
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0), "rand");
        end

        if (exp_q.size() != 0) check_val("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
